// File: rtl/sc_pkg.sv
// Shared RV32I definitions for the single-cycle computer: opcodes, datapath selects, decode helpers.
package sc_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_t;

   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;
   typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_sel_t;
   typedef enum logic [1:0] {NPC_SEQ, NPC_BR, NPC_JAL, NPC_JALR} npc_sel_t;

   function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_sel_t sel);
      case (sel)
         IMM_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
         IMM_B:   return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         IMM_U:   return {ins[31:12], 12'b0};
         IMM_J:   return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default: return {{20{ins[31]}}, ins[31:20]};
      endcase
   endfunction

   // alt selects SUB/SRA; callers only raise it where the encoding allows
   function automatic alu_op_t alu_dec(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/sc_cpu.sv
// Single-cycle RV32I core: decode, immediates, ALU, branch/next-PC, load/store lanes, register file.
// Unknown or malformed encodings retire as NOPs.
module sc_cpu
   import sc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   output logic [31:0] PC,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wdata,
   output logic [3:0]  dm_be,
   output logic        dm_we,
   input  logic [31:0] dm_rdata,
   input  logic [4:0]  reg_sel,
   output logic [31:0] reg_data
);
   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic        f7_zero, f7_alt;
   imm_sel_t    imm_sel;
   wb_sel_t     wb_sel;
   npc_sel_t    npc_sel;
   alu_op_t     alu_op;
   logic        a_pc, b_imm, rf_we, st_en, taken;
   logic [31:0] imm, rs1_v, rs2_v, alu_a, alu_b, alu_res;
   logic [31:0] pc4, pc_imm, npc, ld_val, wb_val;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign opcode  = instr[6:0];
   assign f3      = instr[14:12];
   assign f7_zero = (instr[31:25] == 7'h00);
   assign f7_alt  = (instr[31:25] == 7'h20);

   always_comb begin
      imm_sel = IMM_I;
      wb_sel  = WB_ALU;
      npc_sel = NPC_SEQ;
      alu_op  = ALU_ADD;
      a_pc    = 1'b0;
      b_imm   = 1'b0;
      rf_we   = 1'b0;
      st_en   = 1'b0;
      case (opcode)
         OP_LUI: begin
            imm_sel = IMM_U; wb_sel = WB_IMM; rf_we = 1'b1;
         end
         OP_AUIPC: begin
            imm_sel = IMM_U; a_pc = 1'b1; b_imm = 1'b1; rf_we = 1'b1;
         end
         OP_JAL: begin
            imm_sel = IMM_J; wb_sel = WB_PC4; npc_sel = NPC_JAL; rf_we = 1'b1;
         end
         OP_JALR: begin
            if (f3 == 3'b000) begin
               b_imm = 1'b1; wb_sel = WB_PC4; npc_sel = NPC_JALR; rf_we = 1'b1;
            end
         end
         OP_BRANCH: begin
            imm_sel = IMM_B;
            if (f3[2:1] != 2'b01) npc_sel = NPC_BR;
         end
         OP_LOAD: begin
            b_imm  = 1'b1;
            wb_sel = WB_MEM;
            rf_we  = (f3 != 3'b011) && (f3[2:1] != 2'b11);
         end
         OP_STORE: begin
            imm_sel = IMM_S;
            b_imm   = 1'b1;
            st_en   = !f3[2] && (f3[1:0] != 2'b11);
         end
         OP_IMM: begin
            b_imm  = 1'b1;
            alu_op = alu_dec(f3, (f3 == 3'b101) && instr[30]);
            // only the shift forms constrain the upper bits
            rf_we  = (f3[1:0] != 2'b01) || f7_zero || (f3 == 3'b101 && f7_alt);
         end
         OP_REG: begin
            alu_op = alu_dec(f3, instr[30]);
            rf_we  = f7_zero || (f7_alt && (f3 == 3'b000 || f3 == 3'b101));
         end
         default: ;
      endcase
   end

   assign imm   = imm_gen(instr, imm_sel);
   assign alu_a = a_pc  ? PC  : rs1_v;
   assign alu_b = b_imm ? imm : rs2_v;

   always_comb begin
      case (alu_op)
         ALU_SUB:  alu_res = alu_a - alu_b;
         ALU_SLL:  alu_res = alu_a << alu_b[4:0];
         ALU_SLT:  alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
         ALU_SLTU: alu_res = {31'd0, alu_a < alu_b};
         ALU_XOR:  alu_res = alu_a ^ alu_b;
         ALU_SRL:  alu_res = alu_a >> alu_b[4:0];
         ALU_SRA:  alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
         ALU_OR:   alu_res = alu_a | alu_b;
         ALU_AND:  alu_res = alu_a & alu_b;
         default:  alu_res = alu_a + alu_b;
      endcase
   end

   always_comb begin
      case (f3)
         3'b000:  taken = (rs1_v == rs2_v);
         3'b001:  taken = (rs1_v != rs2_v);
         3'b100:  taken = ($signed(rs1_v) <  $signed(rs2_v));
         3'b101:  taken = ($signed(rs1_v) >= $signed(rs2_v));
         3'b110:  taken = (rs1_v <  rs2_v);
         3'b111:  taken = (rs1_v >= rs2_v);
         default: taken = 1'b0;
      endcase
   end

   assign pc4    = PC + 32'd4;
   assign pc_imm = PC + imm;

   always_comb begin
      case (npc_sel)
         NPC_BR:   npc = taken ? pc_imm : pc4;
         NPC_JAL:  npc = pc_imm;
         NPC_JALR: npc = {alu_res[31:1], 1'b0};
         default:  npc = pc4;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) PC <= RESET_PC;
      else     PC <= npc;
   end

   always_comb begin
      case (alu_res[1:0])
         2'b00:   ld_byte = dm_rdata[7:0];
         2'b01:   ld_byte = dm_rdata[15:8];
         2'b10:   ld_byte = dm_rdata[23:16];
         default: ld_byte = dm_rdata[31:24];
      endcase
   end
   assign ld_half = alu_res[1] ? dm_rdata[31:16] : dm_rdata[15:0];

   always_comb begin
      case (f3)
         3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_val = {24'd0, ld_byte};
         3'b101:  ld_val = {16'd0, ld_half};
         default: ld_val = dm_rdata;
      endcase
   end

   always_comb begin
      case (wb_sel)
         WB_MEM:  wb_val = ld_val;
         WB_PC4:  wb_val = pc4;
         WB_IMM:  wb_val = imm;
         default: wb_val = alu_res;
      endcase
   end

   // narrow stores replicate the data across lanes and let the byte mask pick
   always_comb begin
      dm_wdata = rs2_v;
      dm_be    = 4'b1111;
      case (f3[1:0])
         2'b00: begin
            dm_wdata = {4{rs2_v[7:0]}};
            dm_be    = 4'b0001 << alu_res[1:0];
         end
         2'b01: begin
            dm_wdata = {2{rs2_v[15:0]}};
            dm_be    = alu_res[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   assign dm_addr = alu_res;
   assign dm_we   = st_en & ~rst;

   sc_rf U_RF (
      .clk      (clk),
      .rst      (rst),
      .we       (rf_we),
      .waddr    (instr[11:7]),
      .wdata    (wb_val),
      .raddr1   (instr[19:15]),
      .raddr2   (instr[24:20]),
      .rdata1   (rs1_v),
      .rdata2   (rs2_v),
      .dbg_sel  (reg_sel),
      .dbg_data (reg_data)
   );
endmodule

// File: rtl/sc_dm.sv
// Byte-addressed little-endian data RAM: combinational word read, byte-masked write on posedge.
// Contents are not reset.
module sc_dm #(
   parameter int DM_DEPTH = 128
) (
   input  logic        clk,
   input  logic        we,
   input  logic [3:0]  be,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata
);
   localparam int AW = $clog2(DM_DEPTH);

   logic [31:0]   RAM [0:DM_DEPTH-1];
   logic [AW-1:0] idx;
   logic          unused_addr;

   assign idx         = addr[AW+1:2];
   assign rdata       = RAM[idx];
   assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) RAM[idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end
endmodule

// File: rtl/sc_im.sv
// Instruction ROM, contents loaded by the simulator; combinational fetch.
// Out-of-range PCs wrap through index truncation.
module sc_im #(
   parameter int IM_DEPTH = 128
) (
   input  logic [31:0] pc,
   output logic [31:0] instr
);
   localparam int AW = $clog2(IM_DEPTH);

   logic [31:0] ROM [0:IM_DEPTH-1];
   logic        unused_pc;

   assign instr     = ROM[pc[AW+1:2]];
   assign unused_pc = ^{pc[31:AW+2], pc[1:0]};
endmodule

// File: rtl/sc_rf.sv
// 32x32 register file: two combinational read ports, a debug read port, one posedge write port.
// x0 reads as zero; asynchronous reset clears every entry.
module sc_rf (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2,
   input  logic [4:0]  dbg_sel,
   output logic [31:0] dbg_data
);
   logic [31:0] rf [0:31];

   assign rdata1   = (raddr1 == 5'd0) ? 32'd0 : rf[raddr1];
   assign rdata2   = (raddr2 == 5'd0) ? 32'd0 : rf[raddr2];
   assign dbg_data = (dbg_sel == 5'd0) ? 32'd0 : rf[dbg_sel];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      end else if (we && waddr != 5'd0) begin
         rf[waddr] <= wdata;
      end
   end
endmodule

// File: rtl/sc_comp.sv
// Single-cycle RV32I computer: core, instruction ROM, data RAM, debug register read port.
// rstn is an active-high asynchronous reset despite its name.
module sc_comp #(
   parameter int          IM_DEPTH = 128,
   parameter int          DM_DEPTH = 128,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [4:0]  reg_sel,
   output logic [31:0] reg_data
);
   logic [31:0] PC;
   logic [31:0] instr;
   logic [31:0] dm_addr, dm_wdata, dm_rdata;
   logic [3:0]  dm_be;
   logic        dm_we;

   sc_im #(.IM_DEPTH(IM_DEPTH)) U_IM (
      .pc    (PC),
      .instr (instr)
   );

   sc_cpu #(.RESET_PC(RESET_PC)) U_SCPU (
      .clk      (clk),
      .rst      (rstn),
      .instr    (instr),
      .PC       (PC),
      .dm_addr  (dm_addr),
      .dm_wdata (dm_wdata),
      .dm_be    (dm_be),
      .dm_we    (dm_we),
      .dm_rdata (dm_rdata),
      .reg_sel  (reg_sel),
      .reg_data (reg_data)
   );

   sc_dm #(.DM_DEPTH(DM_DEPTH)) U_DM (
      .clk   (clk),
      .we    (dm_we),
      .be    (dm_be),
      .addr  (dm_addr),
      .wdata (dm_wdata),
      .rdata (dm_rdata)
   );
endmodule

// File: tb/tb_sc_comp.sv
// Directed-program bench for sc_comp: hand-assembled RV32I words with hand-computed results.
module tb_sc_comp;
   logic        clk    = 1'b0;
   logic        clk_en = 1'b1;
   logic        rstn   = 1'b0;
   logic [4:0]  reg_sel = 5'd0;
   logic [31:0] reg_data;
   int          n_checks = 0;
   int          n_errors = 0;

   logic [31:0] prog [0:29] = '{
      32'h00500093, 32'hffd00113, 32'h002081b3, 32'h00700013,  // 00 addi x1,5 / addi x2,-3 / add x3 / addi x0,7
      32'h0100046f, 32'h00100f93, 32'h00100f93, 32'h00100f93,  // 10 jal x8,+16 ; skipped poison
      32'h00302423, 32'h00802203, 32'hfff00293, 32'h00500623,  // 20 sw x3,8 / lw x4,8 / addi x5,-1 / sb x5,12
      32'h00c04303, 32'h00c00483, 32'h123453b7, 32'h00108463,  // 30 lbu x6 / lb x9 / lui x7 / beq x1,x1,+8
      32'h00100f93, 32'h00109463, 32'h00100513, 32'h00a2c463,  // 40 poison / bne x1,x1 / addi x10,1 / blt x5,x10,+8
      32'h00100f93, 32'h00a2e463, 32'h06900593, 32'h00058667,  // 50 poison / bltu x5,x10 / addi x11,0x69 / jalr x12,0(x11)
      32'h00100f93, 32'h00100f93, 32'h402086b3, 32'h40115713,  // 60 poison x2 / sub x13 / srai x14,x2,1
      32'h0020b7b3, 32'h00000073                               // 70 sltu x15,x1,x2 / ecall as NOP
   };

   sc_comp dut (
      .clk      (clk),
      .rstn     (rstn),
      .reg_sel  (reg_sel),
      .reg_data (reg_data)
   );

   always #5 if (clk_en) clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_sel(input string tag, input logic [4:0] sel, input logic [31:0] exp);
      reg_sel = sel;
      #1;
      check(tag, reg_data, exp);
   endtask

   function automatic logic [31:0] rf(input int i);
      return dut.U_SCPU.U_RF.rf[i];
   endfunction

   initial begin
      for (int i = 0; i < 128; i++) dut.U_IM.ROM[i] = 32'h00000013;
      for (int i = 0; i < 30; i++)  dut.U_IM.ROM[i] = prog[i];
      for (int i = 30; i < 76; i++) dut.U_IM.ROM[i] = 32'h00180813;  // addi x16,x16,1
      dut.U_IM.ROM[76] = 32'h0000006f;                             // 0x130: jal x0,0

      #1 rstn = 1'b1;
      @(negedge clk);
      check("rst_pc", dut.PC, 32'h0);
      check("rst_instr", dut.instr, 32'h00500093);
      check_sel("rst_x1", 5'd1, 32'h0);
      rstn = 1'b0;

      step(1); check("addi_x1", rf(1), 32'd5);        check("pc_4", dut.PC, 32'h4);
      step(1); check("addi_x2", rf(2), 32'hFFFFFFFD);
      step(1); check("add_x3", rf(3), 32'd2);         check("pc_c", dut.U_SCPU.PC, 32'hC);
      check_sel("sel_x3", 5'd3, 32'd2);
      step(1); check("x0_keep", rf(0), 32'h0);        check_sel("sel_x0", 5'd0, 32'h0);
      check("pc_10", dut.PC, 32'h10);
      step(1); check("jal_rd", rf(8), 32'h14);        check("jal_pc", dut.PC, 32'h20);
      step(1); check("sw_mem", dut.U_DM.RAM[2], 32'd2);
      step(1); check("lw_x4", rf(4), 32'd2);
      step(3); check("lbu_x6", rf(6), 32'h000000FF);
      step(1); check("lb_x9", rf(9), 32'hFFFFFFFF);
      step(1); check("lui_x7", rf(7), 32'h12345000);  check_sel("sel_x7", 5'd7, 32'h12345000);
      step(1); check("beq_taken", dut.PC, 32'h44);
      step(1); check("bne_not", dut.PC, 32'h48);
      step(2); check("blt_taken", dut.PC, 32'h54);
      step(1); check("bltu_not", dut.PC, 32'h58);
      step(2); check("jalr_pc", dut.PC, 32'h68);      check("jalr_rd", rf(12), 32'h60);
      step(1); check("sub_x13", rf(13), 32'd8);
      step(1); check("srai_x14", rf(14), 32'hFFFFFFFE);
      step(1); check("sltu_x15", rf(15), 32'd1);
      step(1); check("nop_pc", dut.PC, 32'h78);

      step(46); check("end_pc", dut.PC, 32'h130);
      step(4);  check("loop_pc", dut.PC, 32'h130);
      check("pc_known", {31'd0, $isunknown(dut.PC)}, 32'h0);
      check("x16_count", rf(16), 32'd46);
      check("no_poison", rf(31), 32'h0);

      // reset with the clock stopped: RF clears, DM keeps its contents
      clk_en = 1'b0;
      rstn = 1'b1;
      #20;
      check("arst_pc", dut.PC, 32'h0);
      for (int s = 0; s < 32; s++) check_sel($sformatf("arst_sel%0d", s), 5'(s), 32'h0);
      check("arst_dm_word", dut.U_DM.RAM[2], 32'd2);
      check("arst_dm_byte", {24'd0, dut.U_DM.RAM[3][7:0]}, 32'hFF);
      rstn = 1'b0;
      clk_en = 1'b1;

      step(6); check("rerun_pc", dut.PC, 32'h24); check("rerun_x3", rf(3), 32'd2);
      rstn = 1'b1;
      #1;
      check("mid_rst_pc", dut.PC, 32'h0);         check("mid_rst_x3", rf(3), 32'h0);
      step(1);
      check("mid_hold_pc", dut.PC, 32'h0);        check("mid_no_lw", rf(4), 32'h0);
      check("mid_dm_keep", dut.U_DM.RAM[2], 32'd2);
      rstn = 1'b0;
      step(3); check("post_x3", rf(3), 32'd2);   check("post_pc", dut.PC, 32'hC);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
